oven_sequencer: RTL and testbench



---
 rtl/oven_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_oven_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/oven_sequencer.sv
// oven_sequencer
// Bake-cycle controller. Latches the entered setpoint and cook time on a
// start strobe, then models the cavity through PREHEAT, BAKE and DONE while
// owning the 1 Hz time base used by the display and the countdown.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle strobe; begins a bake from IDLE or DONE
//   cancel     in   abort to IDLE (level or strobe)
//   set_temp   in   [9:0]  target temperature, degrees
//   set_min    in   [9:0]  cook time, minutes
//   cur_temp   out  [9:0]  modelled cavity temperature
//   remain_sec out  [15:0] remaining bake seconds
//   ready_led  out  high while baking at setpoint
//   done       out  high in DONE
//   state      out  [1:0]  IDLE=0, PREHEAT=1, BAKE=2, DONE=3
//   tick       out  one-cycle 1 Hz pulse
//
// Build option: define KEEP_WARM_EN to hold the cavity at setpoint in DONE
// (ready_led stays lit) instead of cooling toward ambient.

module oven_sequencer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int AMBIENT   = 70,
    parameter int RAMP_STEP = 5,
    parameter int COOL_STEP = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [9:0]  set_temp,
    input  logic [9:0]  set_min,
    output logic [9:0]  cur_temp,
    output logic [15:0] remain_sec,
    output logic        ready_led,
    output logic        done,
    output logic [1:0]  state,
    output logic        tick
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREHEAT = 2'd1,
        BAKE    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int              CW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0]   CNT_PRE  = CW'(CLK_HZ - 2);
    localparam logic [10:0]     AMB11    = 11'(AMBIENT);
    localparam logic [10:0]     RAMP11   = 11'(RAMP_STEP);
    localparam logic [10:0]     COOL11   = 11'(COOL_STEP);

    state_t         r_state;
    state_t         w_nextState;
    logic [CW-1:0]  r_tickCnt;
    logic           r_tick;
    logic [9:0]     r_tgt;
    logic [9:0]     r_curTemp;
    logic [15:0]    r_remain;
    logic           r_ready;
    logic           r_done;

    logic [10:0]    w_ramp11;
    logic [10:0]    w_cool11;
    logic [9:0]     w_rampTemp;
    logic [9:0]     w_coolTemp;
    logic [9:0]     w_preheatTemp;
    logic [15:0]    w_setSec;
    logic           w_startOk;
    logic [9:0]     w_nextTemp;
    logic [9:0]     w_nextTgt;
    logic [15:0]    w_nextRemain;
    logic           w_nextReady;
    logic           w_nextDone;

    assign cur_temp   = r_curTemp;
    assign remain_sec = r_remain;
    assign ready_led  = r_ready;
    assign done       = r_done;
    assign state      = r_state;
    assign tick       = r_tick;

    // Free-running time base; tick is registered one count early so it is
    // high exactly while the counter sits at its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tickCnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tickCnt <= (r_tickCnt == CNT_LAST) ? '0 : r_tickCnt + 1'b1;
            r_tick    <= (r_tickCnt == CNT_PRE);
        end
    end

    // Saturating ramp/cool arithmetic done at 11 bits so nothing wraps.
    assign w_ramp11      = {1'b0, r_curTemp} + RAMP11;
    assign w_rampTemp    = (w_ramp11 >= {1'b0, r_tgt}) ? r_tgt : w_ramp11[9:0];
    assign w_cool11      = {1'b0, r_curTemp} - COOL11;
    assign w_coolTemp    = ({1'b0, r_curTemp} < (AMB11 + COOL11)) ? AMB11[9:0] : w_cool11[9:0];
    assign w_preheatTemp = r_tick ? w_rampTemp : r_curTemp;
    assign w_setSec      = {6'd0, set_min} * 16'd60;
    assign w_startOk     = start && ((r_state == IDLE) || (r_state == DONE));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; PREHEAT looks at the post-tick temperature so the
    // tick that reaches setpoint also moves to BAKE.
    always_comb begin
        w_nextState = r_state;
        if (cancel) begin
            w_nextState = IDLE;
        end else if (w_startOk) begin
            w_nextState = (set_temp <= r_curTemp) ? BAKE : PREHEAT;
        end else begin
            case (r_state)
                PREHEAT: if (w_preheatTemp == r_tgt) w_nextState = BAKE;
                BAKE:    if (r_remain == 16'd0)      w_nextState = DONE;
                default: w_nextState = r_state;
            endcase
        end
    end

    // Output/datapath next values. Cancel and start take precedence over
    // the tick-driven temperature update on their edge.
    always_comb begin
        w_nextTemp   = r_curTemp;
        w_nextTgt    = r_tgt;
        w_nextRemain = r_remain;
        if (cancel) begin
            w_nextRemain = 16'd0;
        end else if (w_startOk) begin
            w_nextTgt    = set_temp;
            w_nextRemain = w_setSec;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_tick) w_nextTemp = w_coolTemp;
                end
                PREHEAT: begin
                    w_nextTemp = w_preheatTemp;
                end
                BAKE: begin
                    w_nextTemp = r_tgt;
                    if (r_tick && (r_remain != 16'd0)) w_nextRemain = r_remain - 16'd1;
                end
                default: begin
`ifdef KEEP_WARM_EN
                    w_nextTemp = r_tgt;
`else
                    if (r_tick) w_nextTemp = w_coolTemp;
`endif
                end
            endcase
        end
`ifdef KEEP_WARM_EN
        w_nextReady = (w_nextState == BAKE) || (w_nextState == DONE);
`else
        w_nextReady = (w_nextState == BAKE);
`endif
        w_nextDone  = (w_nextState == DONE);
    end

    // Registered datapath and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_curTemp <= AMB11[9:0];
            r_tgt     <= '0;
            r_remain  <= '0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_curTemp <= w_nextTemp;
            r_tgt     <= w_nextTgt;
            r_remain  <= w_nextRemain;
            r_ready   <= w_nextReady;
            r_done    <= w_nextDone;
        end
    end

endmodule

// File: tb/tb_oven_sequencer.sv
// tb_oven_sequencer
// Directed scenarios followed by randomized start/cancel traffic, all checked
// against a cycle-level behavioural model of the bake sequence.

module tb_oven_sequencer;

    localparam int CLK_HZ = 4;
    localparam int AMB    = 70;
    localparam int RAMP   = 5;
    localparam int COOL   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [9:0]  set_temp;
    logic [9:0]  set_min;
    logic [9:0]  cur_temp;
    logic [15:0] remain_sec;
    logic        ready_led;
    logic        done;
    logic [1:0]  state;
    logic        tick;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state: 0 IDLE, 1 PREHEAT, 2 BAKE, 3 DONE.
    int mState, mTemp, mTgt, mRemain, mEdges;
    bit mTick, mReady, mDone;

    oven_sequencer #(
        .CLK_HZ(CLK_HZ), .AMBIENT(AMB), .RAMP_STEP(RAMP), .COOL_STEP(COOL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel),
        .set_temp(set_temp), .set_min(set_min), .cur_temp(cur_temp),
        .remain_sec(remain_sec), .ready_led(ready_led), .done(done),
        .state(state), .tick(tick)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mState = 0; mTemp = AMB; mTgt = 0; mRemain = 0;
        mEdges = 0; mTick = 0; mReady = 0; mDone = 0;
    endtask

    // One clock edge of the reference behaviour, written from the sequencing rules.
    task automatic modelStep(input bit st, input bit cn);
        int oldRemain;
        if (cn) begin
            mState = 0;
            mRemain = 0;
        end else if (st && (mState == 0 || mState == 3)) begin
            mTgt = set_temp;
            mRemain = set_min * 60;
            mState = (set_temp <= mTemp) ? 2 : 1;
        end else begin
            case (mState)
                0: if (mTick) mTemp = (mTemp - COOL > AMB) ? mTemp - COOL : AMB;
                1: begin
                    if (mTick) mTemp = (mTemp + RAMP < mTgt) ? mTemp + RAMP : mTgt;
                    if (mTemp == mTgt) mState = 2;
                end
                2: begin
                    oldRemain = mRemain;
                    mTemp = mTgt;
                    if (mTick && mRemain > 0) mRemain = mRemain - 1;
                    if (oldRemain == 0) mState = 3;
                end
                default: begin
`ifdef KEEP_WARM_EN
                    mTemp = mTgt;
`else
                    if (mTick) mTemp = (mTemp - COOL > AMB) ? mTemp - COOL : AMB;
`endif
                end
            endcase
        end
`ifdef KEEP_WARM_EN
        mReady = (mState == 2) || (mState == 3);
`else
        mReady = (mState == 2);
`endif
        mDone = (mState == 3);
        mEdges++;
        mTick = ((mEdges % CLK_HZ) == CLK_HZ - 1);
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".cur_temp"},   32'(cur_temp),   32'(mTemp));
        chk({tag, ".remain_sec"}, 32'(remain_sec), 32'(mRemain));
        chk({tag, ".ready_led"},  32'(ready_led),  32'(mReady));
        chk({tag, ".done"},       32'(done),       32'(mDone));
        chk({tag, ".state"},      32'(state),      32'(mState));
        chk({tag, ".tick"},       32'(tick),       32'(mTick));
    endtask

    // Drive one cycle of start/cancel, advance the model, and check all outputs.
    task automatic applyStimulus(input bit st, input bit cn);
        start  = st;
        cancel = cn;
        @(posedge clk);
        modelStep(st, cn);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("cyc");
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic runUntil(input string tag, input logic [1:0] want, input int bound);
        for (int i = 0; i < bound && state !== want; i++) applyStimulus(1'b0, 1'b0);
        chk(tag, 32'(state), 32'(want));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0;
        set_temp = 10'd0; set_min = 10'd0;
        modelReset();
        #12;
        chk("rst.cur_temp", 32'(cur_temp), 32'd70);
        chk("rst.remain", 32'(remain_sec), 32'd0);
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.tick", 32'(tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Nominal bake: 70 -> 75 -> 80, then 60 s countdown.
        set_temp = 10'd80; set_min = 10'd1;
        applyStimulus(1'b1, 1'b0);
        chk("nom.preheat", 32'(state), 32'd1);
        runUntil("nom.bake", 2'd2, 40);
        chk("nom.bake_temp", 32'(cur_temp), 32'd80);
        chk("nom.bake_remain", 32'(remain_sec), 32'd60);
        chk("nom.bake_led", 32'(ready_led), 32'd1);
        runUntil("nom.done", 2'd3, 400);
        chk("nom.done_flag", 32'(done), 32'd1);
        chk("nom.done_remain", 32'(remain_sec), 32'd0);
        runCycles(4);
`ifdef KEEP_WARM_EN
        chk("warm.temp1", 32'(cur_temp), 32'd80);
        runCycles(44);
        chk("warm.temp_hold", 32'(cur_temp), 32'd80);
        chk("warm.led", 32'(ready_led), 32'd1);
        chk("warm.done", 32'(done), 32'd1);
        applyStimulus(1'b0, 1'b1);
        runCycles(40);
        chk("warm.cooled", 32'(cur_temp), 32'd70);
`else
        chk("nom.cool78", 32'(cur_temp), 32'd78);
        chk("nom.led_off", 32'(ready_led), 32'd0);
        runCycles(40);
        chk("nom.cooled", 32'(cur_temp), 32'd70);
        applyStimulus(1'b0, 1'b1);
`endif

        // Zero-minute bake at ambient: straight to BAKE, DONE one cycle later.
        set_temp = 10'd70; set_min = 10'd0;
        applyStimulus(1'b1, 1'b0);
        chk("zero.bake", 32'(state), 32'd2);
        applyStimulus(1'b0, 1'b0);
        chk("zero.done", 32'(state), 32'd3);
        chk("zero.remain", 32'(remain_sec), 32'd0);
        applyStimulus(1'b0, 1'b1);

        // Ramp clamp: 70 -> 73 in one tick.
        set_temp = 10'd73; set_min = 10'd1;
        applyStimulus(1'b1, 1'b0);
        runUntil("clamp.bake", 2'd2, 10);
        chk("clamp.temp", 32'(cur_temp), 32'd73);
        applyStimulus(1'b0, 1'b1);
        runCycles(12);
        chk("clamp.cooled", 32'(cur_temp), 32'd70);

        // Cancel mid-BAKE at 30 s remaining.
        set_temp = 10'd80; set_min = 10'd1;
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 400 && remain_sec !== 16'd30; i++) applyStimulus(1'b0, 1'b0);
        chk("cancel.at30", 32'(remain_sec), 32'd30);
        applyStimulus(1'b0, 1'b1);
        chk("cancel.state", 32'(state), 32'd0);
        chk("cancel.remain", 32'(remain_sec), 32'd0);
        chk("cancel.led", 32'(ready_led), 32'd0);
        runCycles(4);
        chk("cancel.t78", 32'(cur_temp), 32'd78);
        runCycles(4);
        chk("cancel.t76", 32'(cur_temp), 32'd76);
        runCycles(20);
        chk("cancel.t70", 32'(cur_temp), 32'd70);

        // Asynchronous reset in the middle of PREHEAT.
        set_temp = 10'd200; set_min = 10'd1;
        applyStimulus(1'b1, 1'b0);
        runCycles(6);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst");
        chk("async_rst.state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        set_temp = 10'd90;
        applyStimulus(1'b1, 1'b0);
        chk("rst_restart.state", 32'(state), 32'd1);

        // Randomized start/cancel traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bit st, cn;
            st = ($urandom_range(0, 24) == 0);
            cn = ($urandom_range(0, 59) == 0);
            if (st) begin
                set_temp = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 999))
                                                       : 10'($urandom_range(40, 110));
                set_min  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                       : 10'($urandom_range(0, 1));
            end
            applyStimulus(st, cn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
